// File: rtl/pub_mon_pkg.sv
// Shared types and defaults for the public trace monitor and its FIFO.
package pub_mon_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      TRACK   = 2'd1,
      SETTLED = 2'd2
   } pub_mon_state_e;

   localparam int PUB_W             = 2;
   localparam int DEF_DEPTH         = 8;
   localparam int DEF_SETTLE_CYCLES = 12;
   localparam int DEF_CNT_W         = 4;

endpackage

// File: rtl/pub_trace_fifo.sv
// Synchronous FIFO with combinational head read; a push on full is accepted
// when a pop happens in the same cycle.
module pub_trace_fifo #(
   parameter int DEPTH = 8,
   parameter int W     = 2
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   push,
   input  logic [W-1:0]           wdata,
   input  logic                   pop,
   output logic [W-1:0]           rdata,
   output logic                   empty,
   output logic                   full,
   output logic [$clog2(DEPTH):0] count
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          do_push;
   logic          do_pop;

   assign empty   = (count == '0);
   assign full    = (count == FULL_CNT);
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign rdata   = mem[rd_ptr];

   // Storage write; contents need no reset since count gates visibility.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= wdata;
      end
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/public_trace_monitor.sv
// Stutter-free, change-only trace of an upstream public output, with change
// count and settle detection. Define PUBLIC_MON_STUTTER_CNT_EN for stutter_count/starved.
module public_trace_monitor
   import pub_mon_pkg::*;
#(
   parameter int DEPTH         = DEF_DEPTH,
   parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
   parameter int CNT_W         = DEF_CNT_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [PUB_W-1:0] public_in,
   input  logic             stutter_in,
   input  logic             rd_en,
   output logic [PUB_W-1:0] rd_data,
   output logic             rd_valid,
   output logic             full,
   output logic             overflow,
   output logic [CNT_W-1:0] change_count,
   output logic             settled,
   output logic [PUB_W-1:0] last_value
`ifdef PUBLIC_MON_STUTTER_CNT_EN
   ,
   output logic [7:0]       stutter_count,
   output logic             starved
`endif
);
   localparam int STAB_W = $clog2(SETTLE_CYCLES + 1);
   localparam logic [STAB_W-1:0] STAB_MAX  = STAB_W'(SETTLE_CYCLES);
   localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(SETTLE_CYCLES - 1);

   pub_mon_state_e         state;
   logic [STAB_W-1:0]      stable_cnt;
   logic                   active;
   logic                   change;
   logic                   pop;
   logic                   push;
   logic                   lost;
   logic                   fifo_empty;
   logic [$clog2(DEPTH):0] fifo_count;

   assign active   = !stutter_in;
   assign change   = active && (public_in != last_value);
   assign pop      = rd_en && !fifo_empty;
   assign push     = change && (!full || pop);
   assign lost     = change && full && !pop;
   assign rd_valid = (fifo_count != '0);

   pub_trace_fifo #(.DEPTH(DEPTH), .W(PUB_W)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .wdata (public_in),
      .pop   (pop),
      .rdata (rd_data),
      .empty (fifo_empty),
      .full  (full),
      .count (fifo_count)
   );

   // Change detection, counters and settle FSM; stutter cycles hold everything.
   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         stable_cnt   <= '0;
         last_value   <= '0;
         change_count <= '0;
         overflow     <= 1'b0;
         settled      <= 1'b0;
      end else if (active) begin
         if (change) begin
            last_value <= public_in;
            if (change_count != '1) change_count <= change_count + 1'b1;
            if (lost) overflow <= 1'b1;
            stable_cnt <= '0;
            state      <= TRACK;
            settled    <= 1'b0;
         end else begin
            case (state)
               IDLE, TRACK: begin
                  if (stable_cnt == STAB_LAST) begin
                     stable_cnt <= STAB_MAX;
                     state      <= SETTLED;
                     settled    <= 1'b1;
                  end else begin
                     stable_cnt <= stable_cnt + 1'b1;
                     state      <= TRACK;
                  end
               end
               SETTLED: begin
                  stable_cnt <= STAB_MAX;
                  settled    <= 1'b1;
               end
               default: begin
                  state      <= IDLE;
                  stable_cnt <= '0;
                  settled    <= 1'b0;
               end
            endcase
         end
      end
   end

`ifdef PUBLIC_MON_STUTTER_CNT_EN
   logic [4:0] stutter_run;

   // Stutter statistics; a run of 16 stutters outside SETTLED flags starvation.
   always_ff @(posedge clk) begin
      if (rst) begin
         stutter_count <= 8'd0;
         stutter_run   <= 5'd0;
         starved       <= 1'b0;
      end else if (stutter_in) begin
         if (stutter_count != 8'hFF) stutter_count <= stutter_count + 8'd1;
         if (stutter_run != 5'd16)   stutter_run   <= stutter_run + 5'd1;
         if ((stutter_run >= 5'd15) && (state != SETTLED)) starved <= 1'b1;
      end else begin
         stutter_run <= 5'd0;
         starved     <= 1'b0;
      end
   end
`endif

endmodule

// File: tb/tb_public_trace_monitor.sv
// Directed self-checking bench for public_trace_monitor (default parameters).
module tb_public_trace_monitor;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [1:0] public_in = 2'd0;
   logic       stutter_in = 1'b0;
   logic       rd_en = 1'b0;
   logic [1:0] rd_data;
   logic       rd_valid;
   logic       full;
   logic       overflow;
   logic [3:0] change_count;
   logic       settled;
   logic [1:0] last_value;
`ifdef PUBLIC_MON_STUTTER_CNT_EN
   logic [7:0] stutter_count;
   logic       starved;
`endif

   int n_checks = 0;
   int n_pass   = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   public_trace_monitor dut (
      .clk          (clk),
      .rst          (rst),
      .public_in    (public_in),
      .stutter_in   (stutter_in),
      .rd_en        (rd_en),
      .rd_data      (rd_data),
      .rd_valid     (rd_valid),
      .full         (full),
      .overflow     (overflow),
      .change_count (change_count),
      .settled      (settled),
      .last_value   (last_value)
`ifdef PUBLIC_MON_STUTTER_CNT_EN
      ,
      .stutter_count(stutter_count),
      .starved      (starved)
`endif
   );

   task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
      n_checks++;
      assert (got === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic step(input logic [1:0] p, input logic s, input logic r);
      public_in  = p;
      stutter_in = s;
      rd_en      = r;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step(2'd0, 1'b0, 1'b0);
      rst = 1'b0;
   endtask

   task automatic chk_reset_state(input string tag);
      chk({tag, ".rd_valid"}, 8'(rd_valid), 8'd0);
      chk({tag, ".full"}, 8'(full), 8'd0);
      chk({tag, ".overflow"}, 8'(overflow), 8'd0);
      chk({tag, ".change_count"}, 8'(change_count), 8'd0);
      chk({tag, ".settled"}, 8'(settled), 8'd0);
      chk({tag, ".last_value"}, 8'(last_value), 8'd0);
   endtask

   initial begin
      // Reset values
      do_reset();
      step(2'd0, 1'b0, 1'b0);
      rst = 1'b1;
      step(2'd0, 1'b0, 1'b0);
      rst = 1'b0;
      chk_reset_state("reset");

      // Twelve stable zero samples settle; nothing is pushed
      for (int i = 0; i < 11; i++) step(2'd0, 1'b0, 1'b0);
      chk("settle_11", 8'(settled), 8'd0);
      step(2'd0, 1'b0, 1'b0);
      chk("settle_12", 8'(settled), 8'd1);
      chk("settle_no_push", 8'(rd_valid), 8'd0);
      chk("settle_cc", 8'(change_count), 8'd0);

      // Sequence 0,2,2,1,3 then pop 2,1,3
      step(2'd0, 1'b0, 1'b0);
      step(2'd2, 1'b0, 1'b0);
      chk("seq_unsettle", 8'(settled), 8'd0);
      chk("seq_lv2", 8'(last_value), 8'd2);
      chk("seq_cc1", 8'(change_count), 8'd1);
      chk("seq_valid", 8'(rd_valid), 8'd1);
      step(2'd2, 1'b0, 1'b0);
      step(2'd1, 1'b0, 1'b0);
      step(2'd3, 1'b0, 1'b0);
      chk("seq_cc3", 8'(change_count), 8'd3);
      chk("seq_head0", 8'(rd_data), 8'd2);
      step(2'd3, 1'b0, 1'b1);
      chk("seq_head1", 8'(rd_data), 8'd1);
      step(2'd3, 1'b0, 1'b1);
      chk("seq_head2", 8'(rd_data), 8'd3);
      chk("seq_valid2", 8'(rd_valid), 8'd1);
      step(2'd3, 1'b0, 1'b1);
      chk("seq_empty", 8'(rd_valid), 8'd0);
      step(2'd3, 1'b0, 1'b1);
      chk("seq_pop_empty", 8'(rd_valid), 8'd0);
      chk("seq_cc_hold", 8'(change_count), 8'd3);

      // Value change only during stutter cycles is invisible
      do_reset();
      step(2'd1, 1'b1, 1'b0);
      step(2'd1, 1'b1, 1'b0);
      step(2'd1, 1'b1, 1'b0);
      step(2'd0, 1'b0, 1'b0);
      chk("stut_valid", 8'(rd_valid), 8'd0);
      chk("stut_lv", 8'(last_value), 8'd0);
      chk("stut_cc", 8'(change_count), 8'd0);

      // Fill, overflow, push-on-full with pop, drain
      do_reset();
      for (int i = 0; i < 8; i++) step((i % 2 == 0) ? 2'd1 : 2'd2, 1'b0, 1'b0);
      chk("fill_full", 8'(full), 8'd1);
      chk("fill_ovf0", 8'(overflow), 8'd0);
      chk("fill_cc8", 8'(change_count), 8'd8);
      step(2'd1, 1'b0, 1'b0);
      chk("ovf_set", 8'(overflow), 8'd1);
      chk("ovf_cc9", 8'(change_count), 8'd9);
      chk("ovf_full", 8'(full), 8'd1);
      chk("ovf_head", 8'(rd_data), 8'd1);
      step(2'd3, 1'b0, 1'b1);
      chk("pp_full", 8'(full), 8'd1);
      chk("pp_cc10", 8'(change_count), 8'd10);
      chk("pp_head", 8'(rd_data), 8'd2);
      step(2'd3, 1'b1, 1'b1);
      chk("drain_notfull", 8'(full), 8'd0);
      for (int i = 0; i < 6; i++) step(2'd3, 1'b1, 1'b1);
      chk("drain_last", 8'(rd_data), 8'd3);
      chk("drain_valid", 8'(rd_valid), 8'd1);
      step(2'd3, 1'b1, 1'b1);
      chk("drain_empty", 8'(rd_valid), 8'd0);
      for (int i = 0; i < 6; i++) step((i % 2 == 0) ? 2'd0 : 2'd1, 1'b0, 1'b1);
      chk("cc_sat", 8'(change_count), 8'd15);
      chk("ovf_sticky", 8'(overflow), 8'd1);

      // Settle, unsettle, stutters do not advance the stable counter
      do_reset();
      for (int i = 0; i < 12; i++) step(2'd0, 1'b0, 1'b0);
      chk("s2_settled", 8'(settled), 8'd1);
      step(2'd3, 1'b0, 1'b0);
      chk("s2_unsettle", 8'(settled), 8'd0);
      for (int i = 0; i < 20; i++) step(2'd3, 1'b1, 1'b0);
      chk("s2_stutter", 8'(settled), 8'd0);
`ifdef PUBLIC_MON_STUTTER_CNT_EN
      chk("s2_starved", 8'(starved), 8'd1);
      chk("s2_stcnt", stutter_count, 8'd20);
`endif
      for (int i = 0; i < 11; i++) step(2'd3, 1'b0, 1'b0);
      chk("s2_11", 8'(settled), 8'd0);
`ifdef PUBLIC_MON_STUTTER_CNT_EN
      chk("s2_starved_clr", 8'(starved), 8'd0);
`endif
      step(2'd3, 1'b0, 1'b0);
      chk("s2_12", 8'(settled), 8'd1);

      // A change on the threshold cycle wins
      do_reset();
      for (int i = 0; i < 11; i++) step(2'd0, 1'b0, 1'b0);
      step(2'd1, 1'b0, 1'b0);
      chk("thr_change", 8'(settled), 8'd0);
      for (int i = 0; i < 11; i++) step(2'd1, 1'b0, 1'b0);
      chk("thr_11", 8'(settled), 8'd0);
      step(2'd1, 1'b0, 1'b0);
      chk("thr_12", 8'(settled), 8'd1);

      // Reset mid-trace with pop and stutter requested
      do_reset();
      step(2'd1, 1'b0, 1'b0);
      step(2'd2, 1'b0, 1'b0);
      step(2'd3, 1'b0, 1'b0);
      step(2'd1, 1'b0, 1'b0);
      step(2'd2, 1'b0, 1'b0);
      chk("mid_cc5", 8'(change_count), 8'd5);
      rst = 1'b1;
      step(2'd2, 1'b1, 1'b1);
      rst = 1'b0;
      chk_reset_state("mid_rst");

`ifdef PUBLIC_MON_STUTTER_CNT_EN
      // Starvation after 16 consecutive stutters in TRACK
      do_reset();
      step(2'd0, 1'b0, 1'b0);
      for (int i = 0; i < 15; i++) step(2'd0, 1'b1, 1'b0);
      chk("starve_15", 8'(starved), 8'd0);
      chk("stcnt_15", stutter_count, 8'd15);
      step(2'd0, 1'b1, 1'b0);
      chk("starve_16", 8'(starved), 8'd1);
      chk("stcnt_16", stutter_count, 8'd16);
      step(2'd0, 1'b0, 1'b0);
      chk("starve_clr", 8'(starved), 8'd0);
`endif

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
